vga_glyph_rain: RTL and testbench

- Parametrised digital-rain pixel engine for the TinyVGA glyph-mode designs.
- Sits between hvsync_generator and the external glyph/palette ROMs, and drives the 6-bit RGB path.
- Replaces the divider-based cell mapping with incremental row/line counters.
- Adds a registered 2-stage pixel pipeline with aligned sync outputs, a phase FSM (intro/rain/paused), pause, restart and selectable rain speed.

---
 rtl/vga_glyph_rain.sv | 211 +++++++++++++++++++++
 tb/tb_vga_glyph_rain.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_glyph_rain.sv
// vga_glyph_rain: digital-rain pixel engine for TinyVGA glyph mode.
// Maps hpos/vpos to glyph cells with incremental row/line counters (no divider),
// animates a rain effect from a vsync-driven frame counter, and drives RGB through
// a 2-stage registered pipeline with matching hsync/vsync delays.
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   hpos, vpos          beam position from hvsync_generator
//   display_on          active video
//   hsync, vsync        raw syncs (vsync active-low); hsync_o/vsync_o delayed 2 clocks
//   pause, restart      hold animation (level) / replay intro (strobe)
//   speed               rain speed, 0 = slowest
//   glyph_index/x/y     glyph ROM address (registered); glyph_pixel is its same-cycle return
//   palette_cid         palette ROM address (registered); palette_color is its return
//   rgb                 pixel colour
//   frame, phase        animation counter, phase (0 INTRO, 1 RAIN, 2 PAUSED)
// Optional macro GLYPH_RAIN_LFSR_EN: glyph flicker taken from a 16-bit LFSR
// stepped per counted frame instead of frame[7:4].
module vga_glyph_rain #(
  parameter int unsigned CELL_W     = 8,
  parameter int unsigned CELL_H     = 12,
  parameter int unsigned H_BITS     = 11,
  parameter int unsigned V_BITS     = 10,
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned NUM_GLYPHS = 51,
  parameter int unsigned COLOR_BITS = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [H_BITS-1:0]         hpos,
  input  logic [V_BITS-1:0]         vpos,
  input  logic                      display_on,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      pause,
  input  logic                      restart,
  input  logic [1:0]                speed,
  output logic [5:0]                glyph_index,
  output logic [$clog2(CELL_W)-1:0] glyph_x,
  output logic [3:0]                glyph_y,
  input  logic                      glyph_pixel,
  output logic [2:0]                palette_cid,
  input  logic [COLOR_BITS-1:0]     palette_color,
  output logic [COLOR_BITS-1:0]     rgb,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic [FRAME_BITS-1:0]     frame,
  output logic [1:0]                phase
);

  localparam int unsigned CX = $clog2(CELL_W);
  localparam int unsigned DW = FRAME_BITS + 2;
  localparam logic [2:0]  K_MAX = (FRAME_BITS - 7 >= 4) ? 3'd4 : 3'(FRAME_BITS - 7);

  typedef enum logic [1:0] {PH_INTRO = 2'd0, PH_RAIN = 2'd1, PH_PAUSED = 2'd2} phase_t;

  phase_t                r_phase;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_vsync_q;
  logic [5:0]            r_row_q;
  logic [3:0]            r_line_q;
  logic [V_BITS-1:0]     r_vpos_q;
  logic                  r_head1, r_blank1, r_drop1, r_de1, r_hs1, r_vs1;

  logic [5:0]    w_row;
  logic [3:0]    w_line;
  logic [7:0]    w_c;
  logic [6:0]    w_xm, w_fsh, w_v, w_idx;
  logic          w_s, w_n, w_t, w_count, w_drop;
  logic [2:0]    w_k_raw, w_k;
  logic [5:0]    w_h;
  logic [3:0]    w_flick;
  logic [DW-1:0] w_rowh;

  // Effective row/line: restart at vpos 0, step one line whenever vpos moves.
  always_comb begin
    w_row  = r_row_q;
    w_line = r_line_q;
    if (vpos == '0) begin
      w_row  = '0;
      w_line = '0;
    end else if (vpos != r_vpos_q) begin
      if (5'(r_line_q) + 5'd1 == 5'(CELL_H)) begin
        w_line = '0;
        w_row  = (r_row_q == 6'd63) ? r_row_q : r_row_q + 6'd1;
      end else begin
        w_line = r_line_q + 4'd1;
      end
    end
  end

  // Column features.
  assign w_c  = 8'(hpos >> CX);
  assign w_xm = {w_c[7] ^ w_c[3], w_c[1], w_c[4], w_c[1], w_c[6], w_c[0], w_c[2]};
  assign w_s  = ^w_c[6:0];
  assign w_n  = w_c[1] ^ w_c[3] ^ w_c[5];

  // Slower speed or even-parity columns use a larger frame shift.
  assign w_k_raw = 3'd3 - 3'(speed) + 3'(!w_s);
  assign w_k     = (w_k_raw > K_MAX) ? K_MAX : w_k_raw;
  assign w_fsh   = 7'(r_frame >> w_k);
  assign w_v     = w_fsh - 7'(w_row) - w_xm;

  // Intro drop-in: a column's rows appear as the frame count passes them.
  assign w_rowh = DW'(w_row) * DW'(CELL_H);
  assign w_drop = (r_phase == PH_INTRO) && ((DW'(w_xm) + (w_rowh >> w_s)) > DW'(r_frame));

  // Glyph selection with occasional flicker.
  assign w_h = {w_c[2] ^ w_row[0], w_c[0] ^ w_row[1], w_c[1] ^ w_row[2],
                w_c[4] ^ w_row[3], w_c[3] ^ w_row[4], w_c[5] ^ w_row[5]};
  assign w_t = &{w_c[0] ^ w_row[2] ^ r_frame[7], w_c[1] ^ w_row[1] ^ r_frame[8],
                 w_c[2] ^ w_row[3] ^ r_frame[9], w_c[3] ^ w_row[0]};

  assign w_count = r_vsync_q & ~vsync & ~pause;

`ifdef GLYPH_RAIN_LFSR_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16/14/13/11, one step per counted frame.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_lfsr <= 16'hACE1;
    end else if (w_count) begin
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  assign w_flick = w_t ? r_lfsr[3:0] : 4'd0;
`else
  assign w_flick = w_t ? r_frame[7:4] : 4'd0;
`endif

  // h + flick never exceeds twice the glyph count, so two reductions suffice.
  always_comb begin
    w_idx = 7'(w_h) + 7'(w_flick);
    if (w_idx >= 7'(NUM_GLYPHS)) w_idx = w_idx - 7'(NUM_GLYPHS);
    if (w_idx >= 7'(NUM_GLYPHS)) w_idx = w_idx - 7'(NUM_GLYPHS);
  end

  // Frame counter and phase FSM; restart wins over a coincident edge or wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame   <= '0;
      r_phase   <= PH_INTRO;
      r_vsync_q <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      if (restart) begin
        r_frame <= '0;
        r_phase <= PH_INTRO;
      end else begin
        if (w_count) r_frame <= r_frame + FRAME_BITS'(1);
        case (r_phase)
          PH_INTRO:  if (w_count && (&r_frame)) r_phase <= PH_RAIN;
          PH_RAIN:   if (pause) r_phase <= PH_PAUSED;
          PH_PAUSED: if (!pause) r_phase <= PH_RAIN;
          default:   r_phase <= PH_INTRO;
        endcase
      end
    end
  end

  assign frame = r_frame;
  assign phase = r_phase;

  // Cell counters and the 2-stage pixel pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_q     <= '0;
      r_line_q    <= '0;
      r_vpos_q    <= '0;
      glyph_index <= '0;
      glyph_x     <= '0;
      glyph_y     <= '0;
      palette_cid <= '0;
      r_head1     <= 1'b0;
      r_blank1    <= 1'b0;
      r_drop1     <= 1'b0;
      r_de1       <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      hsync_o     <= 1'b1;
      vsync_o     <= 1'b1;
      rgb         <= '0;
    end else begin
      r_row_q     <= w_row;
      r_line_q    <= w_line;
      r_vpos_q    <= vpos;
      glyph_index <= 6'(w_idx);
      glyph_x     <= hpos[CX-1:0];
      glyph_y     <= w_line;
      palette_cid <= ~w_v[5:3];
      r_head1     <= (w_v[2:0] == 3'd0);
      r_blank1    <= w_n | (&w_v[6:5]);
      r_drop1     <= w_drop;
      r_de1       <= display_on;
      r_hs1       <= hsync;
      r_vs1       <= vsync;
      hsync_o     <= r_hs1;
      vsync_o     <= r_vs1;
      // Not-yet-dropped intro pixels show the inverted palette colour.
      if (r_de1 && glyph_pixel && r_drop1) begin
        rgb <= ~palette_color;
      end else if (r_de1 && glyph_pixel && !r_blank1) begin
        rgb <= r_head1 ? '1 : palette_color;
      end else begin
        rgb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_glyph_rain.sv
// Self-checking bench for vga_glyph_rain: randomized beam/sync stimulus against a
// behavioural model (row = vpos/CELL_H, frames counted from vsync falling edges).
module tb_vga_glyph_rain;

  localparam int CELL_W = 8;
  localparam int CELL_H = 12;
  localparam int H_BITS = 11;
  localparam int V_BITS = 10;
  localparam int FB     = 10;
  localparam int NG     = 51;
  localparam int CB     = 6;
  localparam int VMAX   = 800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, display_on, hsync, vsync, pause, restart, glyph_pixel;
  logic [H_BITS-1:0] hpos;
  logic [V_BITS-1:0] vpos;
  logic [1:0]        speed;
  logic [CB-1:0]     palette_color;
  logic [5:0]        glyph_index;
  logic [2:0]        glyph_x;
  logic [3:0]        glyph_y;
  logic [2:0]        palette_cid;
  logic [CB-1:0]     rgb;
  logic              hsync_o, vsync_o;
  logic [FB-1:0]     frame;
  logic [1:0]        phase;

  vga_glyph_rain dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync(hsync), .vsync(vsync), .pause(pause), .restart(restart), .speed(speed),
    .glyph_index(glyph_index), .glyph_x(glyph_x), .glyph_y(glyph_y),
    .glyph_pixel(glyph_pixel), .palette_cid(palette_cid), .palette_color(palette_color),
    .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o), .frame(frame), .phase(phase)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_row(input int vp);
    int r;
    r = vp / CELL_H;
    return (r > 63) ? 63 : r;
  endfunction

  function automatic int bitof(input int x, input int i);
    return (x >> i) & 1;
  endfunction

  function automatic void m_pix(input int hp, input int vp, input int fr, input int ph,
                                input int sp, input int lf,
                                output int idx, output int cid, output int head,
                                output int blank, output int drop);
    int col, row, xm, s, n, k, v, h, t, fl;
    col = (hp / CELL_W) % 256;
    row = m_row(vp);
    xm  = 64 * (bitof(col, 7) ^ bitof(col, 3)) + 32 * bitof(col, 1) + 16 * bitof(col, 4)
        + 8 * bitof(col, 1) + 4 * bitof(col, 6) + 2 * bitof(col, 0) + bitof(col, 2);
    s   = $countones(col % 128) % 2;
    n   = bitof(col, 1) ^ bitof(col, 3) ^ bitof(col, 5);
    k   = 3 - sp + ((s != 0) ? 0 : 1);
    if (k > FB - 7) k = FB - 7;
    v = (((fr >> k) % 128) - row - xm) % 128;
    if (v < 0) v = v + 128;
    head  = (v % 8 == 0) ? 1 : 0;
    blank = (n != 0 || v / 32 == 3) ? 1 : 0;
    cid   = 7 - (v / 8) % 8;
    drop  = (ph == 0 && (xm + ((row * CELL_H) >> s)) > fr) ? 1 : 0;
    h = 32 * (bitof(col, 2) ^ bitof(row, 0)) + 16 * (bitof(col, 0) ^ bitof(row, 1))
      + 8 * (bitof(col, 1) ^ bitof(row, 2)) + 4 * (bitof(col, 4) ^ bitof(row, 3))
      + 2 * (bitof(col, 3) ^ bitof(row, 4)) + (bitof(col, 5) ^ bitof(row, 5));
    t = (bitof(col, 0) ^ bitof(row, 2) ^ bitof(fr, 7)) & (bitof(col, 1) ^ bitof(row, 1) ^ bitof(fr, 8))
      & (bitof(col, 2) ^ bitof(row, 3) ^ bitof(fr, 9)) & (bitof(col, 3) ^ bitof(row, 0));
`ifdef GLYPH_RAIN_LFSR_EN
    fl = (t != 0) ? lf % 16 : 0;
`else
    fl = (t != 0) ? (fr / 16) % 16 : 0;
    if (lf < 0) fl = 0;
`endif
    idx = (h + fl) % NG;
  endfunction

  function automatic int lfsr_next(input int l);
    int b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction

  int m_frame, m_phase, m_vsq, m_lfsr;
  bit m_known;
  int s1_idx, s1_gx, s1_gy, s1_cid, s1_head, s1_blank, s1_drop, s1_de, s1_hs, s1_vs;
  bit s1_known;
  int e_rgb, e_hso, e_vso;
  bit e_rgb_known;
  bit started = 1'b0;

  always @(posedge clk) begin
    int idx, cid, hd, bl, dr, old_ph;
    bit cnt;
    if (reset) begin
      m_frame = 0; m_phase = 0; m_vsq = 0; m_lfsr = 'hACE1;
      m_known = (vpos == '0);
      s1_idx = 0; s1_gx = 0; s1_gy = 0; s1_cid = 0; s1_head = 0; s1_blank = 0;
      s1_drop = 0; s1_de = 0; s1_hs = 1; s1_vs = 1; s1_known = 1'b1;
      e_rgb = 0; e_rgb_known = 1'b1; e_hso = 1; e_vso = 1;
    end else begin
      e_rgb_known = s1_known;
      if (s1_de == 0 || !glyph_pixel) e_rgb = 0;
      else if (s1_drop != 0)          e_rgb = 63 - int'(palette_color);
      else if (s1_blank != 0)         e_rgb = 0;
      else if (s1_head != 0)          e_rgb = 63;
      else                            e_rgb = int'(palette_color);
      e_hso = s1_hs; e_vso = s1_vs;
      s1_hs = int'(hsync); s1_vs = int'(vsync);
      if (vpos == '0) m_known = 1'b1;
      m_pix(int'(hpos), int'(vpos), m_frame, m_phase, int'(speed), m_lfsr, idx, cid, hd, bl, dr);
      s1_idx = idx; s1_cid = cid; s1_head = hd; s1_blank = bl; s1_drop = dr;
      s1_gx = int'(hpos) % CELL_W; s1_gy = int'(vpos) % CELL_H;
      s1_de = int'(display_on); s1_known = m_known;
      cnt = (m_vsq != 0) && !vsync && !pause;
      m_vsq = int'(vsync);
      if (restart) begin
        m_frame = 0; m_phase = 0; m_lfsr = 'hACE1;
      end else begin
        old_ph = m_phase;
        if (cnt) begin
          if (old_ph == 0 && m_frame == (1 << FB) - 1) m_phase = 1;
          m_frame = (m_frame + 1) % (1 << FB);
          m_lfsr  = lfsr_next(m_lfsr);
        end
        if (old_ph == 1 && pause) m_phase = 2;
        else if (old_ph == 2 && !pause) m_phase = 1;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("glyph_x", int'(glyph_x), s1_gx);
      chk("idx_range", int'(glyph_index < 6'd51), 1);
      if (s1_known) begin
        chk("glyph_index", int'(glyph_index), s1_idx);
        chk("glyph_y", int'(glyph_y), s1_gy);
        chk("palette_cid", int'(palette_cid), s1_cid);
      end
      if (e_rgb_known) chk("rgb", int'(rgb), e_rgb);
      chk("hsync_o", int'(hsync_o), e_hso);
      chk("vsync_o", int'(vsync_o), e_vso);
      chk("frame", int'(frame), m_frame);
      chk("phase", int'(phase), m_phase);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_inputs();
    hpos          = H_BITS'($urandom_range(0, 2047));
    display_on    = ($urandom_range(0, 3) != 0);
    hsync         = 1'($urandom_range(0, 1));
    speed         = 2'($urandom_range(0, 3));
    glyph_pixel   = ($urandom_range(0, 3) != 0);
    palette_color = CB'($urandom_range(0, 63));
  endtask

  task automatic tick(input bit adv);
    rnd_inputs();
    if (adv || $urandom_range(0, 1) == 1)
      vpos = (int'(vpos) == VMAX - 1) ? '0 : vpos + 10'd1;
    cyc();
  endtask

  task automatic vedge(input bit rs);
    vsync = 1'b1;
    tick(1'b0);
    vsync   = 1'b0;
    restart = rs;
    tick(1'b0);
    restart = 1'b0;
  endtask

  initial begin
    int idx, cid, hd, bl, dr;
    reset = 1'b1; restart = 1'b0; pause = 1'b0; vsync = 1'b1; hsync = 1'b1;
    vpos = '0; hpos = '0; display_on = 1'b0; speed = '0; glyph_pixel = 1'b0; palette_color = '0;
    cyc();
    started = 1'b1;
    cyc();
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_hsync_o", int'(hsync_o), 1);
    chk("rst_vsync_o", int'(vsync_o), 1);
    chk("rst_glyph_index", int'(glyph_index), 0);

    // Pin the model with hand-derived values.
    chk("model_row523", m_row(523), 43);
    chk("model_row799", m_row(799), 63);
    m_pix(37, 100, 9, 1, 3, 0, idx, cid, hd, bl, dr);
    chk("model_idx", idx, 36);
    chk("model_cid", cid, 7);
    chk("model_head", hd, 1);
    chk("model_blank", bl, 0);

    reset = 1'b0;
    // Full vpos sweep including row saturation past vpos 767.
    for (int v = 0; v < VMAX; v++) begin
      repeat (2) begin
        rnd_inputs();
        vpos = V_BITS'(v);
        cyc();
      end
    end

    repeat (3) vedge(1'b0);
`ifdef GLYPH_RAIN_LFSR_EN
    chk("model_lfsr3", m_lfsr, 'h559C);
    chk("dut_lfsr3", int'(dut.r_lfsr), 'h559C);
`endif
    repeat (1020) vedge(1'b0);
    chk("frame_1023", int'(frame), 1023);
    chk("phase_intro_1023", int'(phase), 0);
    vedge(1'b1);
    chk("restart_frame", int'(frame), 0);
    chk("restart_phase", int'(phase), 0);
`ifdef GLYPH_RAIN_LFSR_EN
    chk("dut_lfsr_reload", int'(dut.r_lfsr), 'hACE1);
`endif
    repeat (1024) vedge(1'b0);
    chk("wrap_frame", int'(frame), 0);
    chk("wrap_phase", int'(phase), 1);
    repeat (9) vedge(1'b0);
    chk("frame_9", int'(frame), 9);

    // Directed head pixel at hpos 37, vpos 100, frame 9, RAIN.
    while (vpos != 10'd100) tick(1'b1);
    repeat (2) begin
      rnd_inputs(); hsync = 1'b1; vsync = 1'b0; cyc();
    end
    hpos = 11'd37; display_on = 1'b1; speed = 2'd3; glyph_pixel = 1'b1;
    palette_color = 6'h15; hsync = 1'b0; vsync = 1'b1;
    cyc();
    chk("dir_glyph_index", int'(glyph_index), 36);
    chk("dir_glyph_x", int'(glyph_x), 5);
    chk("dir_glyph_y", int'(glyph_y), 4);
    chk("dir_palette_cid", int'(palette_cid), 7);
    chk("dir_hsync_lag1", int'(hsync_o), 1);
    chk("dir_vsync_lag1", int'(vsync_o), 0);
    hsync = 1'b1;
    cyc();
    chk("dir_rgb", int'(rgb), 63);
    chk("dir_hsync_lag2", int'(hsync_o), 0);
    chk("dir_vsync_lag2", int'(vsync_o), 1);
    cyc();
    chk("dir_hsync_lag3", int'(hsync_o), 1);

    // Pause holds the frame in RAIN.
    pause = 1'b1;
    repeat (5) vedge(1'b0);
    chk("pause_frame", int'(frame), 9);
    chk("pause_phase", int'(phase), 2);
    pause = 1'b0;
    tick(1'b1);
    chk("resume_phase", int'(phase), 1);
    vedge(1'b0);
    chk("resume_frame", int'(frame), 10);

    // Random soak with pause/restart activity.
    for (int i = 0; i < 300; i++) begin
      pause = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) == 0) vedge($urandom_range(0, 40) == 0);
      else tick(1'b0);
    end
    pause = 1'b0;

    // Mid-frame reset, intro pause, then resync at the next vpos 0.
    while (vpos != 10'd300) tick(1'b1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_rgb", int'(rgb), 0);
    chk("mid_rst_frame", int'(frame), 0);
    chk("mid_rst_phase", int'(phase), 0);
    chk("mid_rst_idx", int'(glyph_index), 0);
    chk("mid_rst_vsync_o", int'(vsync_o), 1);
    reset = 1'b0;
    pause = 1'b1;
    repeat (3) vedge(1'b0);
    chk("intro_pause_frame", int'(frame), 0);
    chk("intro_pause_phase", int'(phase), 0);
    pause = 1'b0;
    for (int i = 0; i < 1400; i++) begin
      if ($urandom_range(0, 7) == 0) vedge(1'b0);
      else tick(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
